// File: rtl/carfield_padmux.sv
// Register-programmed pad multiplexer: per-pad function select, OE inversion,
// sticky lock and a Hi-Z guard window whenever a pad changes function.

module carfield_padmux_pad #(
  parameter int unsigned NumFuncs    = 4,
  parameter int unsigned GuardCycles = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                we_i,
  input  logic [3:0]          wsel_i,
  input  logic                winv_i,
  input  logic                wlock_i,
  input  logic [NumFuncs-1:0] func_o_i,
  input  logic [NumFuncs-1:0] func_oe_i,
  output logic [NumFuncs-1:0] func_i_o,
  output logic                pad_o_o,
  output logic                pad_oe_o,
  input  logic                pad_i_i,
  output logic                busy_o,
  output logic                lock_o,
  output logic [31:0]         cfg_o
);

  typedef enum logic {ACTIVE, GUARD} state_e;

  localparam int unsigned CntW = (GuardCycles > 1) ? $clog2(GuardCycles) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(GuardCycles - 1);

  state_e          state_q, state_d;
  logic [3:0]      cur_q, cur_d, pend_q, pend_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            inv_q, inv_d, lock_q, lock_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ACTIVE;
      cur_q   <= '0;
      pend_q  <= '0;
      cnt_q   <= '0;
      inv_q   <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      inv_q   <= inv_d;
      lock_q  <= lock_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    inv_d   = inv_q;
    lock_d  = lock_q;
    if (we_i) begin
      inv_d  = winv_i;
      lock_d = lock_q | wlock_i;
    end
    unique case (state_q)
      ACTIVE: begin
        if (we_i && wsel_i != cur_q) begin
          state_d = GUARD;
          pend_d  = wsel_i;
          cnt_d   = CntLoad;
        end
      end
      GUARD: begin
        // A new target restarts the window; re-writing the pending target does not.
        if (we_i && wsel_i != pend_q) begin
          pend_d = wsel_i;
          cnt_d  = CntLoad;
        end else if (cnt_q == '0) begin
          state_d = ACTIVE;
          cur_d   = pend_q;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = ACTIVE;
    endcase
  end

  always_comb begin
    pad_o_o  = 1'b0;
    pad_oe_o = 1'b0;
    func_i_o = '0;
    if (state_q == ACTIVE) begin
      for (int f = 0; f < int'(NumFuncs); f++) begin
        if (cur_q == 4'(f)) begin
          pad_o_o     = func_o_i[f];
          pad_oe_o    = func_oe_i[f] ^ inv_q;
          func_i_o[f] = pad_i_i;
        end
      end
    end
  end

  assign busy_o = (state_q == GUARD);
  assign lock_o = lock_q;
  assign cfg_o  = {22'd0, lock_q, inv_q, 4'd0, (state_q == GUARD) ? pend_q : cur_q};

endmodule

module carfield_padmux #(
  parameter int unsigned NumPads      = 32,
  parameter int unsigned NumFuncs     = 4,
  parameter int unsigned GuardCycles  = 4,
  parameter int unsigned RegAddrWidth = 12
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               reg_valid_i,
  input  logic                               reg_write_i,
  input  logic [RegAddrWidth-1:0]            reg_addr_i,
  input  logic [31:0]                        reg_wdata_i,
  output logic                               reg_ready_o,
  output logic [31:0]                        reg_rdata_o,
  output logic                               reg_error_o,
  input  logic [NumFuncs-1:0][NumPads-1:0]   func_o_i,
  input  logic [NumFuncs-1:0][NumPads-1:0]   func_oe_i,
  output logic [NumFuncs-1:0][NumPads-1:0]   func_i_o,
  output logic [NumPads-1:0]                 pad_o_o,
  output logic [NumPads-1:0]                 pad_oe_o,
  input  logic [NumPads-1:0]                 pad_i_i,
  output logic [NumPads-1:0]                 busy_o
);

  localparam int unsigned WordW = RegAddrWidth - 2;

  logic [WordW-1:0]              word;
  logic                          aligned, is_stat, is_pad, hit_locked, sel_bad;
  logic                          err, wr_ok;
  logic [NumPads-1:0]            pad_hit, lock_vec;
  logic [NumPads-1:0][31:0]      cfg;
  logic [31:0]                   rd_cfg;
  logic [NumPads-1:0][NumFuncs-1:0] col_o, col_oe, col_i;
  logic                          unused_wdata;

  assign word       = reg_addr_i[RegAddrWidth-1:2];
  assign aligned    = (reg_addr_i[1:0] == 2'b00);
  assign is_stat    = aligned && (word == WordW'(NumPads));
  assign is_pad     = |pad_hit;
  assign hit_locked = |(pad_hit & lock_vec);
  assign sel_bad    = {1'b0, reg_wdata_i[3:0]} >= 5'(NumFuncs);

  // Any rejected write leaves every pad untouched, lock and inv included.
  assign err = reg_valid_i && ((!is_pad && !is_stat) ||
               (reg_write_i && (is_stat || hit_locked || sel_bad)));
  assign wr_ok = reg_valid_i && reg_write_i && !err;

  assign unused_wdata = ^{reg_wdata_i[31:10], reg_wdata_i[7:4]};

  for (genvar p = 0; p < NumPads; p++) begin : g_pad
    assign pad_hit[p] = aligned && (word == WordW'(p));

    for (genvar f = 0; f < NumFuncs; f++) begin : g_fn
      assign col_o[p][f]    = func_o_i[f][p];
      assign col_oe[p][f]   = func_oe_i[f][p];
      assign func_i_o[f][p] = col_i[p][f];
    end

    carfield_padmux_pad #(
      .NumFuncs    (NumFuncs),
      .GuardCycles (GuardCycles)
    ) u_pad (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .we_i      (wr_ok && pad_hit[p]),
      .wsel_i    (reg_wdata_i[3:0]),
      .winv_i    (reg_wdata_i[8]),
      .wlock_i   (reg_wdata_i[9]),
      .func_o_i  (col_o[p]),
      .func_oe_i (col_oe[p]),
      .func_i_o  (col_i[p]),
      .pad_o_o   (pad_o_o[p]),
      .pad_oe_o  (pad_oe_o[p]),
      .pad_i_i   (pad_i_i[p]),
      .busy_o    (busy_o[p]),
      .lock_o    (lock_vec[p]),
      .cfg_o     (cfg[p])
    );
  end

  always_comb begin
    rd_cfg = '0;
    for (int p = 0; p < int'(NumPads); p++) begin
      if (pad_hit[p]) rd_cfg = cfg[p];
    end
  end

  assign reg_ready_o = reg_valid_i;
  assign reg_error_o = err;
  assign reg_rdata_o = (reg_valid_i && !reg_write_i) ? (is_stat ? 32'(busy_o) : rd_cfg) : '0;

endmodule

// File: tb/tb_carfield_padmux.sv
// Directed bench for carfield_padmux with a per-pad behavioural model checked every cycle.

module tb_carfield_padmux;
  localparam int NP = 32, NF = 4, G = 4, AW = 12;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   reg_valid, reg_write;
  logic [AW-1:0]          reg_addr;
  logic [31:0]            reg_wdata;
  logic                   reg_ready, reg_error;
  logic [31:0]            reg_rdata;
  logic [NF-1:0][NP-1:0]  func_o, func_oe, func_i;
  logic [NP-1:0]          pad_o, pad_oe, pad_i, busy;

  carfield_padmux #(
    .NumPads(NP), .NumFuncs(NF), .GuardCycles(G), .RegAddrWidth(AW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .reg_valid_i(reg_valid), .reg_write_i(reg_write), .reg_addr_i(reg_addr),
    .reg_wdata_i(reg_wdata), .reg_ready_o(reg_ready), .reg_rdata_o(reg_rdata),
    .reg_error_o(reg_error),
    .func_o_i(func_o), .func_oe_i(func_oe), .func_i_o(func_i),
    .pad_o_o(pad_o), .pad_oe_o(pad_oe), .pad_i_i(pad_i), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  bit chk_en = 0;

  // Model: committed function, pending target and remaining Hi-Z cycles per pad.
  int m_cur[NP], m_pend[NP], m_left[NP];
  bit m_inv[NP], m_lock[NP];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void m_resp(input logic v, input logic w, input logic [AW-1:0] a,
                                 input logic [31:0] d, output logic e, output logic [31:0] rd);
    int wd;
    logic [3:0] s;
    wd = int'(a) / 4;
    e  = 1'b0;
    rd = '0;
    if (!v) return;
    if (a[1:0] != 2'b00 || wd > NP) e = 1'b1;
    else if (w) begin
      if (wd == NP) e = 1'b1;
      else if (m_lock[wd] || int'(d[3:0]) >= NF) e = 1'b1;
    end else if (wd == NP) begin
      for (int p = 0; p < NP; p++) rd[p] = (m_left[p] > 0);
    end else begin
      s  = 4'(m_left[wd] > 0 ? m_pend[wd] : m_cur[wd]);
      rd = {22'd0, m_lock[wd], m_inv[wd], 4'd0, s};
    end
  endfunction

  logic        me;
  logic [31:0] mr;
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int p = 0; p < NP; p++) begin
        m_cur[p] = 0; m_pend[p] = 0; m_left[p] = 0; m_inv[p] = 0; m_lock[p] = 0;
      end
    end else begin
      m_resp(reg_valid, reg_write, reg_addr, reg_wdata, me, mr);
      for (int p = 0; p < NP; p++) begin
        bit restart;
        restart = 0;
        if (reg_valid && reg_write && !me && int'(reg_addr) / 4 == p) begin
          int s;
          s = int'(reg_wdata[3:0]);
          if ((m_left[p] == 0 && s != m_cur[p]) || (m_left[p] > 0 && s != m_pend[p])) begin
            m_pend[p] = s;
            m_left[p] = G;
            restart   = 1;
          end
          m_inv[p]  = reg_wdata[8];
          m_lock[p] = m_lock[p] | reg_wdata[9];
        end
        if (!restart && m_left[p] > 0) begin
          m_left[p]--;
          if (m_left[p] == 0) m_cur[p] = m_pend[p];
        end
      end
    end
  end

  logic [31:0] eo, eoe, eb;
  logic [NF-1:0][31:0] efi;
  logic        ce;
  logic [31:0] cr;
  always @(negedge clk) begin
    if (chk_en) begin
      eo = '0; eoe = '0; eb = '0; efi = '0;
      for (int p = 0; p < NP; p++) begin
        if (m_left[p] > 0) eb[p] = 1'b1;
        else begin
          eo[p]  = func_o[m_cur[p]][p];
          eoe[p] = func_oe[m_cur[p]][p] ^ m_inv[p];
          efi[m_cur[p]][p] = pad_i[p];
        end
      end
      m_resp(reg_valid, reg_write, reg_addr, reg_wdata, ce, cr);
      chk("m_pad_o", pad_o, eo);
      chk("m_pad_oe", pad_oe, eoe);
      chk("m_busy", busy, eb);
      for (int f = 0; f < NF; f++) chk($sformatf("m_func_i[%0d]", f), func_i[f], efi[f]);
      chk("m_ready", 32'(reg_ready), 32'(reg_valid));
      chk("m_rdata", reg_rdata, cr);
      chk("m_error", 32'(reg_error), 32'(ce));
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic acc(input logic w, input logic [AW-1:0] a, input logic [31:0] d,
                     input logic e_err, input logic [31:0] e_rd);
    reg_valid = 1'b1; reg_write = w; reg_addr = a; reg_wdata = d;
    @(negedge clk);
    chk($sformatf("err@%h", a), 32'(reg_error), 32'(e_err));
    chk($sformatf("rdata@%h", a), reg_rdata, e_rd);
    @(posedge clk); #1;
    reg_valid = 1'b0; reg_write = 1'b0; reg_addr = '0; reg_wdata = '0;
  endtask

  task automatic expect_guard(input int p, input int n);
    repeat (n) begin
      @(negedge clk);
      chk($sformatf("busy[%0d]", p), 32'(busy[p]), 32'd1);
      chk($sformatf("hiz_oe[%0d]", p), 32'(pad_oe[p]), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; reg_valid = 1'b0; reg_write = 1'b0; reg_addr = '0; reg_wdata = '0;
    func_o[0] = 32'hA5A5A5A5; func_oe[0] = 32'hFFFFFFFF;
    func_o[1] = 32'h0F0F0F0F; func_oe[1] = 32'h0000FFFF;
    func_o[2] = 32'h3C3C3C3C; func_oe[2] = 32'hFFFFFFFF;
    func_o[3] = 32'h12345678; func_oe[3] = 32'hF0F0F0F0;
    pad_i = 32'hDEADBEEF;
    @(posedge clk); #1;
    chk_en = 1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Reset state: everything on function 0.
    @(negedge clk);
    chk("rst_pad_o", pad_o, 32'hA5A5A5A5);
    chk("rst_pad_oe", pad_oe, 32'hFFFFFFFF);
    chk("rst_busy", busy, 32'h0);
    @(posedge clk); #1;
    acc(0, 12'h000, 0, 0, 0);
    acc(0, 12'h00C, 0, 0, 0);
    acc(0, 12'h07C, 0, 0, 0);
    acc(0, 12'h080, 0, 0, 0);

    // Pad 3 -> function 2 with a 4-cycle guard.
    acc(1, 12'h00C, 32'h2, 0, 0);
    expect_guard(3, 4);
    @(negedge clk);
    chk("p3_busy_done", 32'(busy[3]), 0);
    chk("p3_pad_o", 32'(pad_o[3]), 1);
    chk("p3_func_i2", 32'(func_i[2][3]), 1);
    chk("p3_func_i0", 32'(func_i[0][3]), 0);
    @(posedge clk); #1;

    // Pad 5: guard restarted in its second cycle.
    acc(1, 12'h014, 32'h1, 0, 0);
    acc(0, 12'h080, 0, 0, 32'h20);
    acc(1, 12'h014, 32'h3, 0, 0);
    expect_guard(5, 4);
    @(negedge clk);
    chk("p5_busy_done", 32'(busy[5]), 0);
    chk("p5_func_i3", 32'(func_i[3][5]), 1);
    chk("p5_func_i1", 32'(func_i[1][5]), 0);
    @(posedge clk); #1;
    acc(0, 12'h014, 0, 0, 32'h3);

    // Pad 7: inversion only, no guard.
    func_oe[0] = 32'hFFFFFF7F;
    idle(1);
    @(negedge clk); chk("p7_oe_before", 32'(pad_oe[7]), 0); @(posedge clk); #1;
    acc(1, 12'h01C, 32'h100, 0, 0);
    @(negedge clk);
    chk("p7_oe_inv", 32'(pad_oe[7]), 1);
    chk("p7_busy", 32'(busy[7]), 0);
    @(posedge clk); #1;
    acc(0, 12'h01C, 0, 0, 32'h100);

    // Lock and error cases.
    acc(1, 12'h004, 32'h201, 0, 0);
    idle(4);
    acc(1, 12'h004, 32'h2, 1, 0);
    acc(0, 12'h004, 0, 0, 32'h201);
    @(negedge clk); chk("p1_stays_f1", 32'(pad_o[1]), 1); @(posedge clk); #1;
    acc(1, 12'h000, 32'h4, 1, 0);
    acc(0, 12'h000, 0, 0, 0);
    acc(1, 12'h084, 32'h1, 1, 0);
    acc(1, 12'h080, 32'h0, 1, 0);
    acc(0, 12'h084, 0, 1, 0);
    acc(0, 12'hFFC, 0, 1, 0);

    // Pad 9: re-writing the pending target does not extend the guard.
    acc(1, 12'h024, 32'h2, 0, 0);
    acc(1, 12'h024, 32'h2, 0, 0);
    acc(0, 12'h024, 0, 0, 32'h2);
    expect_guard(9, 2);
    @(negedge clk); chk("p9_done", 32'(busy[9]), 0); @(posedge clk); #1;

    // Reset in the middle of a pad 3 guard.
    pad_i = 32'h0F0F1234;
    acc(1, 12'h00C, 32'h1, 0, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst2_busy", busy, 32'h0);
    chk("rst2_pad_o", pad_o, 32'hA5A5A5A5);
    chk("rst2_pad_oe", pad_oe, 32'hFFFFFF7F);
    @(posedge clk); #1;
    acc(0, 12'h00C, 0, 0, 0);
    acc(0, 12'h004, 0, 0, 0);
    acc(0, 12'h01C, 0, 0, 0);
    acc(1, 12'h004, 32'h2, 0, 0);
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
